// File: rtl/jtag_regs_pkg.sv
// jtag_pa: shared constants and decode types for the JTAG instruction and
// data register bank.
package jtag_pa;

    // Instruction codes; BYPASS is all ones and is truncated to IR_WIDTH by users.
    localparam logic [31:0] INSTR_BYPASS = 32'hFFFF_FFFF;
    localparam logic [31:0] INSTR_IDCODE = 32'd1;
    localparam logic [31:0] INSTR_USER   = 32'd2;

    // Low bits loaded into the IR on Capture-IR; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    // Which data register the current instruction selects.
    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_USER   = 2'd2
    } ty_INSTR;

endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: WIDTH-bit scan register with parallel capture and
// LSB-first shift; it holds its value when neither strobe is active.
//   clk, rst     : clock, synchronous active-high reset to RESET_VAL
//   capture      : load capture_val (wins over shift)
//   shift        : load {tdi, sr[WIDTH-1:1]}
//   tdi          : serial in
//   capture_val  : parallel capture value
//   sr           : register contents; sr[0] is the serial-out bit
module jtag_shift_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             shift,
    input  logic             tdi,
    input  logic [WIDTH-1:0] capture_val,
    output logic [WIDTH-1:0] sr
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    // A one-bit register simply takes tdi when shifting.
    if (WIDTH == 1) begin : g_w1
        assign shifted = tdi;
    end else begin : g_wn
        assign shifted = {tdi, sr_q[WIDTH-1:1]};
    end

    // Next-state: capture > shift > hold.
    always_comb begin
        sr_d = sr_q;
        if (capture) begin
            sr_d = capture_val;
        end else if (shift) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= RESET_VAL;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/jtag_regs.sv
// jtag_regs: JTAG instruction register plus BYPASS/IDCODE/USER data registers,
// driven by TAP state strobes; produces the serial TDO stream.
// Optional feature macro: JTAG_USER_DR_EN enables the USER register, its
// decode and the parallel capture/update interface.
//   i_tclk, i_trst          : test clock, synchronous active-high reset
//   i_tdi                   : serial data in
//   i_stateIs*Dr/*Ir        : TAP state strobes
//   i_userCapture           : parallel value captured into USER
//   o_tdo, o_tdoEn          : serial data out (combinational) and its enable
//   o_instr                 : current instruction
//   o_userData, o_userUpdate: committed USER value and its one-cycle strobe
module jtag_regs
    import jtag_pa::*;
#(
    parameter int unsigned  IR_WIDTH     = 4,
    parameter logic [31:0]  IDCODE_VALUE = 32'h1000_0001,
    parameter int unsigned  USER_WIDTH   = 8
) (
    input  logic                  i_tclk,
    input  logic                  i_trst,
    input  logic                  i_tdi,
    input  logic                  i_stateIsCaptureDr,
    input  logic                  i_stateIsShiftDr,
    input  logic                  i_stateIsUpdateDr,
    input  logic                  i_stateIsCaptureIr,
    input  logic                  i_stateIsShiftIr,
    input  logic                  i_stateIsUpdateIr,
    input  logic [USER_WIDTH-1:0] i_userCapture,
    output logic                  o_tdo,
    output logic                  o_tdoEn,
    output logic [IR_WIDTH-1:0]   o_instr,
    output logic [USER_WIDTH-1:0] o_userData,
    output logic                  o_userUpdate
);

    localparam int unsigned        IDCODE_WIDTH = 32;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(IR_CAPTURE_LSBS);

    logic ir_any, ir_cap, ir_shift, ir_upd;
    logic dr_cap, dr_shift, dr_upd;

    // Resolve overlapping strobes: capture > shift > update, IR before DR.
    always_comb begin
        ir_any   = i_stateIsCaptureIr | i_stateIsShiftIr | i_stateIsUpdateIr;
        ir_cap   = i_stateIsCaptureIr;
        ir_shift = i_stateIsShiftIr & ~i_stateIsCaptureIr;
        ir_upd   = i_stateIsUpdateIr & ~i_stateIsCaptureIr & ~i_stateIsShiftIr;
        dr_cap   = i_stateIsCaptureDr & ~ir_any;
        dr_shift = i_stateIsShiftDr & ~ir_any & ~i_stateIsCaptureDr;
        dr_upd   = i_stateIsUpdateDr & ~ir_any & ~i_stateIsCaptureDr & ~i_stateIsShiftDr;
    end

    // Instruction register: scan stage plus updated instruction.
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] instr_q, instr_d;

    jtag_shift_reg #(.WIDTH(IR_WIDTH), .RESET_VAL(IR_CAPTURE)) u_ir (
        .clk         (i_tclk),
        .rst         (i_trst),
        .capture     (ir_cap),
        .shift       (ir_shift),
        .tdi         (i_tdi),
        .capture_val (IR_CAPTURE),
        .sr          (ir_sr)
    );

    always_comb begin
        instr_d = instr_q;
        if (ir_upd) begin
            instr_d = ir_sr;
        end
    end

    // Decode; unknown codes (and USER when the feature is absent) select BYPASS.
    ty_INSTR sel;
    always_comb begin
        sel = SEL_BYPASS;
        if (instr_q == IR_WIDTH'(INSTR_BYPASS)) begin
            sel = SEL_BYPASS;
        end else if (instr_q == IR_WIDTH'(INSTR_IDCODE)) begin
            sel = SEL_IDCODE;
`ifdef JTAG_USER_DR_EN
        end else if (instr_q == IR_WIDTH'(INSTR_USER)) begin
            sel = SEL_USER;
`endif
        end
    end

    // IDCODE register.
    logic [IDCODE_WIDTH-1:0] idcode_sr;

    jtag_shift_reg #(.WIDTH(IDCODE_WIDTH), .RESET_VAL('0)) u_idcode (
        .clk         (i_tclk),
        .rst         (i_trst),
        .capture     (dr_cap & (sel == SEL_IDCODE)),
        .shift       (dr_shift & (sel == SEL_IDCODE)),
        .tdi         (i_tdi),
        .capture_val (IDCODE_VALUE),
        .sr          (idcode_sr)
    );

    // BYPASS register.
    logic bypass_q, bypass_d;
    always_comb begin
        bypass_d = bypass_q;
        if (sel == SEL_BYPASS) begin
            if (dr_cap) begin
                bypass_d = 1'b0;
            end else if (dr_shift) begin
                bypass_d = i_tdi;
            end
        end
    end

`ifdef JTAG_USER_DR_EN
    // USER register with committed parallel copy and update pulse.
    logic [USER_WIDTH-1:0] user_sr;
    logic [USER_WIDTH-1:0] user_data_q, user_data_d;
    logic                  user_update_q, user_update_d;

    jtag_shift_reg #(.WIDTH(USER_WIDTH), .RESET_VAL('0)) u_user (
        .clk         (i_tclk),
        .rst         (i_trst),
        .capture     (dr_cap & (sel == SEL_USER)),
        .shift       (dr_shift & (sel == SEL_USER)),
        .tdi         (i_tdi),
        .capture_val (i_userCapture),
        .sr          (user_sr)
    );

    always_comb begin
        user_data_d   = user_data_q;
        user_update_d = 1'b0;
        if (dr_upd && (sel == SEL_USER)) begin
            user_data_d   = user_sr;
            user_update_d = 1'b1;
        end
    end

    always_ff @(posedge i_tclk) begin
        if (i_trst) begin
            user_data_q   <= '0;
            user_update_q <= 1'b0;
        end else begin
            user_data_q   <= user_data_d;
            user_update_q <= user_update_d;
        end
    end

    assign o_userData   = user_data_q;
    assign o_userUpdate = user_update_q;
`else
    logic unused_user;
    assign unused_user  = ^{i_userCapture, dr_upd};
    assign o_userData   = '0;
    assign o_userUpdate = 1'b0;
`endif

    always_ff @(posedge i_tclk) begin
        if (i_trst) begin
            instr_q  <= IR_WIDTH'(INSTR_IDCODE);
            bypass_q <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            bypass_q <= bypass_d;
        end
    end

    // Serial out follows the raw shift strobes.
    always_comb begin
        o_tdo = 1'b0;
        if (i_stateIsShiftIr) begin
            o_tdo = ir_sr[0];
        end else if (i_stateIsShiftDr) begin
            case (sel)
                SEL_IDCODE: o_tdo = idcode_sr[0];
`ifdef JTAG_USER_DR_EN
                SEL_USER:   o_tdo = user_sr[0];
`endif
                default:    o_tdo = bypass_q;
            endcase
        end
    end

    assign o_tdoEn = i_stateIsShiftIr | i_stateIsShiftDr;
    assign o_instr = instr_q;

endmodule

// File: tb/tb_jtag_regs.sv
// tb_jtag_regs: directed scans against jtag_regs with a TDO/USER scoreboard.
// Expectations for the USER scan follow whether JTAG_USER_DR_EN is defined.
module tb_jtag_regs;

    logic       clk = 1'b0;
    logic       trst;
    logic       tdi;
    logic       cap_dr, sh_dr, up_dr, cap_ir, sh_ir, up_ir;
    logic [7:0] user_cap;
    logic       tdo, tdo_en;
    logic [3:0] instr;
    logic [7:0] user_data;
    logic       user_upd;

    localparam logic [5:0] S_IDLE  = 6'b000000;
    localparam logic [5:0] S_CAPDR = 6'b100000;
    localparam logic [5:0] S_SHDR  = 6'b010000;
    localparam logic [5:0] S_UPDR  = 6'b001000;
    localparam logic [5:0] S_CAPIR = 6'b000100;
    localparam logic [5:0] S_SHIR  = 6'b000010;
    localparam logic [5:0] S_UPIR  = 6'b000001;

    int vectors = 0;
    int miscompares = 0;

    logic exp_tdo[$];
    logic [7:0] exp_user[$];

    jtag_regs #(.IR_WIDTH(4), .IDCODE_VALUE(32'h1000_0001), .USER_WIDTH(8)) dut (
        .i_tclk             (clk),
        .i_trst             (trst),
        .i_tdi              (tdi),
        .i_stateIsCaptureDr (cap_dr),
        .i_stateIsShiftDr   (sh_dr),
        .i_stateIsUpdateDr  (up_dr),
        .i_stateIsCaptureIr (cap_ir),
        .i_stateIsShiftIr   (sh_ir),
        .i_stateIsUpdateIr  (up_ir),
        .i_userCapture      (user_cap),
        .o_tdo              (tdo),
        .o_tdoEn            (tdo_en),
        .o_instr            (instr),
        .o_userData         (user_data),
        .o_userUpdate       (user_upd)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pop one expectation per presented TDO bit / USER update.
    always @(negedge clk) begin
        if (tdo_en) begin
            if (exp_tdo.size() == 0) begin
                check("tdo_unexpected", 32'(tdo_en), 32'd0);
            end else begin
                check("tdo_bit", 32'(tdo), 32'(exp_tdo.pop_front()));
            end
        end
        if (user_upd) begin
            if (exp_user.size() == 0) begin
                check("user_update_unexpected", 32'(user_upd), 32'd0);
            end else begin
                check("user_data", 32'(user_data), 32'(exp_user.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!trst) begin
            assert ($countones({cap_dr, sh_dr, up_dr, cap_ir, sh_ir, up_ir}) <= 1)
                else $error("overlapping TAP strobes");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] s, input logic d);
        {cap_dr, sh_dr, up_dr, cap_ir, sh_ir, up_ir} = s;
        tdi = d;
        tick();
        {cap_dr, sh_dr, up_dr, cap_ir, sh_ir, up_ir} = S_IDLE;
        tdi = 1'b0;
    endtask

    // Capture-IR then shift in 'value'; expected TDO is the capture pattern 0001.
    task automatic scan_ir(input logic [3:0] value);
        logic [3:0] cap_pat;
        cap_pat = 4'b0001;
        drive(S_CAPIR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_tdo.push_back(cap_pat[i]);
            drive(S_SHIR, value[i]);
        end
    endtask

    task automatic scan_dr(input int n, input logic [63:0] tdi_bits, input logic [63:0] exp_bits);
        drive(S_CAPDR, 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_tdo.push_back(exp_bits[i]);
            drive(S_SHDR, tdi_bits[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {cap_dr, sh_dr, up_dr, cap_ir, sh_ir, up_ir} = S_IDLE;
        tdi      = 1'b0;
        user_cap = 8'h00;
        trst     = 1'b1;
        tick();
        tick();
        check("rst_instr",    32'(instr),     32'd1);
        check("rst_userdata", 32'(user_data), 32'd0);
        check("rst_userupd",  32'(user_upd),  32'd0);
        check("rst_tdo",      32'(tdo),       32'd0);
        check("rst_tdoen",    32'(tdo_en),    32'd0);
        trst = 1'b0;
        tick();

        // IDCODE is selected out of reset.
        scan_dr(32, 64'd0, 64'h0000_0000_1000_0001);
        check("idcode_instr", 32'(instr), 32'd1);

        // Load BYPASS; instruction changes only after the Update-IR cycle.
        scan_ir(4'hF);
        check("ir_pre_update", 32'(instr), 32'd1);
        drive(S_UPIR, 1'b0);
        check("ir_bypass", 32'(instr), 32'hF);

        // BYPASS: TDI 1,0,1,1,0 -> TDO 0,1,0,1,1.
        scan_dr(5, 64'b01101, 64'b11010);
        tick();

        // USER instruction.
        scan_ir(4'h2);
        drive(S_UPIR, 1'b0);
        check("ir_user", 32'(instr), 32'h2);
        user_cap = 8'hA5;
`ifdef JTAG_USER_DR_EN
        scan_dr(8, 64'h3C, 64'hA5);
        exp_user.push_back(8'h3C);
        drive(S_UPDR, 1'b0);
        check("user_data_after_upd", 32'(user_data), 32'h3C);
        check("user_upd_pulse",      32'(user_upd),  32'd1);
        tick();
        check("user_upd_one_cycle",  32'(user_upd),  32'd0);
        check("user_data_hold",      32'(user_data), 32'h3C);
`else
        scan_dr(8, 64'h3C, 64'h78);
        drive(S_UPDR, 1'b0);
        check("user_data_tied", 32'(user_data), 32'd0);
        check("user_upd_tied",  32'(user_upd),  32'd0);
        tick();
        check("user_upd_quiet", 32'(user_upd),  32'd0);
`endif

        // Reset in the middle of a USER scan.
        user_cap = 8'h5A;
        drive(S_CAPDR, 1'b0);
        for (int i = 0; i < 3; i++) begin
`ifdef JTAG_USER_DR_EN
            exp_tdo.push_back(user_cap[i]);
`else
            exp_tdo.push_back(i != 0);
`endif
            drive(S_SHDR, 1'b1);
        end
        trst = 1'b1;
        tick();
        trst = 1'b0;
        check("midrst_instr",    32'(instr),     32'd1);
        check("midrst_userdata", 32'(user_data), 32'd0);
        tick();
        scan_dr(32, 64'd0, 64'h0000_0000_1000_0001);

        // Shifting past 32 bits recirculates TDI: first TDI bit returns at shift 32.
        scan_dr(34, 64'd1, 64'h0000_0001_1000_0001);

        tick();
        tick();
        check("tdo_queue_drained",  32'(exp_tdo.size()),  32'd0);
        check("user_queue_drained", 32'(exp_user.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
